// File: rtl/pipe_run_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_run_ctrl
// Run-control sequencer for the 16-bit pipelined core. It produces the single
// pipeline advance enable that gates the PC, the fetch/ID register and all
// inter-stage registers. It supports:
//   - free-run from the run switch
//   - single/multi-cycle step from a debounced push button
//   - a PC breakpoint that stops the pipeline while the PC holds bp_addr
// Status for LEDs and the seven-segment display is exported alongside.
//
// Parameters
//   DEBOUNCE    consecutive cycles the synchronized step level must differ from
//               the debounced level before the debounced level flips (1..65535)
//   STEP_CYCLES pipe_en cycles granted per step press (1..255)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   step_btn   in   raw step button, active-high, asynchronous to clk
//   run_sw     in   raw run switch, asynchronous to clk; 1 = run
//   bp_en      in   breakpoint enable (static)
//   bp_addr    in   [15:0] breakpoint PC value (static)
//   pc         in   [15:0] current PC register output
//   pipe_en    out  pipeline advance enable (combinational from state and pc)
//   halted     out  1 in HALT or BREAK
//   bp_flag    out  1 in BREAK
//   state_out  out  [1:0] HALT=0, RUN=1, STEP=2, BREAK=3
//   cycle_cnt  out  [15:0] saturating count of cycles with pipe_en=1
// -----------------------------------------------------------------------------
module pipe_run_ctrl #(
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_btn,
  input  logic        run_sw,
  input  logic        bp_en,
  input  logic [15:0] bp_addr,
  input  logic [15:0] pc,
  output logic        pipe_en,
  output logic        halted,
  output logic        bp_flag,
  output logic [1:0]  state_out,
  output logic [15:0] cycle_cnt
);

  localparam int unsigned DB_W   = 16;
  localparam int unsigned STEP_W = 8;
  localparam int unsigned CNT_W  = 16;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  // Synchronizer and debounce state
  logic              r_step_s1;
  logic              r_step_s;
  logic              r_run_s1;
  logic              r_run_s;
  logic              r_db;
  logic              r_db_d;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_step_pulse;

  // Sequencer state
  state_t            r_state;
  logic [STEP_W-1:0] r_step_cnt;
  logic              r_bp_skip;
  logic [CNT_W-1:0]  r_cycle_cnt;

  logic              w_step_diff;
  logic              w_bp_hit;
  logic              w_pipe_en;
  logic              w_break_exit;

  // Two-flop synchronizers; nothing else looks at the raw board inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_s1 <= 1'b0;
      r_step_s  <= 1'b0;
      r_run_s1  <= 1'b0;
      r_run_s   <= 1'b0;
    end else begin
      r_step_s1 <= step_btn;
      r_step_s  <= r_step_s1;
      r_run_s1  <= run_sw;
      r_run_s   <= r_run_s1;
    end
  end

  // Debounce: the level must stay different for DEBOUNCE cycles before it is
  // accepted, for both press and release.
  assign w_step_diff = r_step_s ^ r_db;

  // The press edge is registered so the sequencer sees a flop, never the
  // debounce compare; one pulse per accepted press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db         <= 1'b0;
      r_db_d       <= 1'b0;
      r_db_cnt     <= '0;
      r_step_pulse <= 1'b0;
    end else begin
      r_db_d       <= r_db;
      r_step_pulse <= r_db & ~r_db_d;
      if (!w_step_diff) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db     <= r_step_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  // Breakpoint compare is combinational so the PC never advances past bp_addr.
  assign w_bp_hit     = bp_en & (r_state == S_RUN) & (pc == bp_addr) & ~r_bp_skip;
  assign w_pipe_en    = ((r_state == S_RUN) & ~w_bp_hit) | (r_state == S_STEP);
  assign w_break_exit = (r_state == S_BREAK) & (~r_run_s | r_step_pulse);

  // Run-control sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_HALT;
      r_step_cnt <= '0;
    end else begin
      case (r_state)
        S_HALT: begin
          // Run takes priority; a coincident step pulse is dropped.
          if (r_run_s) begin
            r_state <= S_RUN;
          end else if (r_step_pulse) begin
            r_state    <= S_STEP;
            r_step_cnt <= '0;
          end
        end
        S_RUN: begin
          if (!r_run_s) begin
            r_state <= S_HALT;
          end else if (w_bp_hit) begin
            r_state <= S_BREAK;
          end
        end
        S_STEP: begin
          // Step burst runs to completion; run switch and new presses wait.
          if (r_step_cnt == STEP_LAST) begin
            r_state <= S_HALT;
          end else begin
            r_step_cnt <= r_step_cnt + STEP_W'(1);
          end
        end
        S_BREAK: begin
          if (!r_run_s) begin
            r_state <= S_HALT;
          end else if (r_step_pulse) begin
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  // Skip flag masks the breakpoint after leaving BREAK until the PC moves off
  // bp_addr, so resuming does not immediately re-trigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bp_skip <= 1'b0;
    end else if (w_break_exit) begin
      r_bp_skip <= 1'b1;
    end else if (r_bp_skip && (pc != bp_addr)) begin
      r_bp_skip <= 1'b0;
    end
  end

  // Saturating count of advanced cycles; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt <= '0;
    end else if (w_pipe_en && (r_cycle_cnt != CNT_MAX)) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
    end
  end

  assign pipe_en   = w_pipe_en;
  assign halted    = (r_state == S_HALT) | (r_state == S_BREAK);
  assign bp_flag   = (r_state == S_BREAK);
  assign state_out = r_state;
  assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_run_ctrl
// Two instances share the board inputs: u_dut1 (STEP_CYCLES=1) and u_dut3
// (STEP_CYCLES=3), both DEBOUNCE=4. Each has its own PC register that the bench
// advances from the reference model's expected pipe_en. A behavioural model
// tracks synchronizer delay, debounce run-lengths, remaining step cycles and
// breakpoint skip, and every negedge the DUT outputs are compared to it.
// -----------------------------------------------------------------------------
module tb_pipe_run_ctrl;

  localparam int DB     = 4;
  localparam int S_HALT = 0;
  localparam int S_RUN  = 1;
  localparam int S_STEP = 2;
  localparam int S_BRK  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_btn = 1'b0;
  logic        run_sw = 1'b0;
  logic        bp_en = 1'b0;
  logic [15:0] bp_addr = 16'h0;
  logic [15:0] pc0 = 16'h0;
  logic [15:0] pc1 = 16'h0;
  logic        pe0, pe1, h0, h1, bf0, bf1;
  logic [1:0]  so0, so1;
  logic [15:0] cc0, cc1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  pipe_run_ctrl #(.DEBOUNCE(DB), .STEP_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .step_btn(step_btn), .run_sw(run_sw),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc0),
    .pipe_en(pe0), .halted(h0), .bp_flag(bf0), .state_out(so0), .cycle_cnt(cc0)
  );

  pipe_run_ctrl #(.DEBOUNCE(DB), .STEP_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .step_btn(step_btn), .run_sw(run_sw),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc1),
    .pipe_en(pe1), .halted(h1), .bp_flag(bf1), .state_out(so1), .cycle_cnt(cc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_run_a, m_run_s, m_stp_a, m_stp_s, m_db, m_db_prev, m_pulse;
  int m_diff;
  int m_st[2];
  int m_left[2];
  int m_cc[2];
  bit m_skip[2];

  function automatic int nsteps(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] pc_of(input int k);
    return (k == 0) ? pc0 : pc1;
  endfunction

  function automatic bit m_hit(input int k);
    return bp_en && (m_st[k] == S_RUN) && (pc_of(k) == bp_addr) && !m_skip[k];
  endfunction

  function automatic bit m_pe(input int k);
    return ((m_st[k] == S_RUN) && !m_hit(k)) || (m_st[k] == S_STEP);
  endfunction

  function automatic logic [15:0] next_pc(input logic [15:0] p, input bit adv);
    if (!adv) return p;
    return (p == 16'd15) ? 16'd0 : p + 16'd1;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit run_s, pulse, pe, hit;
    if (rst) begin
      m_run_a = 0; m_run_s = 0; m_stp_a = 0; m_stp_s = 0;
      m_db = 0; m_db_prev = 0; m_pulse = 0; m_diff = 0;
      for (int k = 0; k < 2; k++) begin
        m_st[k] = S_HALT; m_left[k] = 0; m_cc[k] = 0; m_skip[k] = 0;
      end
      pc0 <= 16'h0;
      pc1 <= 16'h0;
    end else begin
      run_s = m_run_s;
      pulse = m_pulse;
      for (int k = 0; k < 2; k++) begin
        pe  = m_pe(k);
        hit = m_hit(k);
        if (pe && m_cc[k] < 65535) m_cc[k]++;
        if (m_st[k] == S_BRK && (!run_s || pulse)) m_skip[k] = 1;
        else if (pc_of(k) != bp_addr) m_skip[k] = 0;
        case (m_st[k])
          S_HALT: begin
            if (run_s) m_st[k] = S_RUN;
            else if (pulse) begin m_st[k] = S_STEP; m_left[k] = nsteps(k); end
          end
          S_RUN: begin
            if (!run_s) m_st[k] = S_HALT;
            else if (hit) m_st[k] = S_BRK;
          end
          S_STEP: begin
            m_left[k]--;
            if (m_left[k] == 0) m_st[k] = S_HALT;
          end
          default: begin
            if (!run_s) m_st[k] = S_HALT;
            else if (pulse) m_st[k] = S_RUN;
          end
        endcase
        if (k == 0) pc0 <= next_pc(pc0, pe);
        else        pc1 <= next_pc(pc1, pe);
      end
      // Debounce expressed as a run length of disagreeing samples.
      m_pulse   = m_db && !m_db_prev;
      m_db_prev = m_db;
      if (m_stp_s != m_db) begin
        m_diff++;
        if (m_diff >= DB) begin m_db = m_stp_s; m_diff = 0; end
      end else begin
        m_diff = 0;
      end
      m_stp_s = m_stp_a; m_stp_a = step_btn;
      m_run_s = m_run_a; m_run_a = run_sw;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("pipe_en_1", pe0, m_pe(0));
      chk("state_1", so0, m_st[0]);
      chk("halted_1", h0, (m_st[0] == S_HALT) || (m_st[0] == S_BRK));
      chk("bp_flag_1", bf0, m_st[0] == S_BRK);
      chk("cycle_cnt_1", cc0, m_cc[0]);
      chk("pipe_en_3", pe1, m_pe(1));
      chk("state_3", so1, m_st[1]);
      chk("halted_3", h1, (m_st[1] == S_HALT) || (m_st[1] == S_BRK));
      chk("bp_flag_3", bf1, m_st[1] == S_BRK);
      chk("cycle_cnt_3", cc1, m_cc[1]);
    end
  end

  task automatic do_reset();
    @(negedge clk); #1;
    step_btn = 0; run_sw = 0; rst = 1;
    @(negedge clk); #1;
    rst = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt0, cnt1, first, runs1, lat, hold;
    bit found, prev1, saw_step;

    #1 rst = 1;
    chk_on = 1;

    // Reset held with run on and step toggling.
    run_sw = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_pipe_en", pe0, 0);
      chk("rst_state", so0, S_HALT);
      chk("rst_halted", h0, 1);
      chk("rst_cycle_cnt", cc0, 0);
      #1 step_btn = ~step_btn;
    end
    @(negedge clk); #1 rst = 0;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (so0 == 2'd1 && lat == 0) lat = i;
    end
    chk("run_latency", lat, 3);

    // Single and multi step from one long press, then a short glitch.
    do_reset();
    bp_en = 0;
    @(negedge clk); #1 step_btn = 1;
    cnt0 = 0; cnt1 = 0; first = 0; runs1 = 0; prev1 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (pe0) begin cnt0++; if (first == 0) first = i; end
      if (pe1) begin cnt1++; if (!prev1) runs1++; end
      prev1 = pe1;
      if (i == 20) begin #1 step_btn = 0; end
    end
    chk("step_pulses", cnt0, 1);
    chk("step_latency", first, 8);
    chk("step_cycle_cnt", cc0, 1);
    chk("mstep_cycles", cnt1, 3);
    chk("mstep_bursts", runs1, 1);
    chk("mstep_cycle_cnt", cc1, 3);
    chk("mstep_halt", so1, S_HALT);

    @(negedge clk); #1 step_btn = 1;
    @(negedge clk); @(negedge clk); #1 step_btn = 0;
    cnt0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pe0 || pe1) cnt0++;
    end
    chk("glitch_pulses", cnt0, 0);

    // Breakpoint at PC 5, resume by step, re-break after wrap.
    do_reset();
    bp_en = 1; bp_addr = 16'h0005; run_sw = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (pc0 == 16'h5) found = 1;
    end
    chk("bp_reached", found, 1);
    chk("bp_pipe_en_low", pe0, 0);
    @(negedge clk);
    chk("bp_state", so0, S_BRK);
    chk("bp_flag", bf0, 1);
    chk("bp_pc_hold", pc0, 16'h5);
    @(negedge clk); #1 step_btn = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (so0 == 2'd1) found = 1;
    end
    chk("resume_run", found, 1);
    #1 step_btn = 0;
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (pc0 == 16'h6) found = 1;
    end
    chk("resume_pc6", found, 1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (so0 == 2'd3) found = 1;
    end
    chk("rebreak", found, 1);
    chk("rebreak_pc", pc0, 16'h5);

    // Run and step pulse reach HALT in the same cycle: run wins.
    do_reset();
    bp_en = 0;
    @(negedge clk); #1 step_btn = 1;
    saw_step = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (so0 == 2'd2 || so1 == 2'd2) saw_step = 1;
      if (i == 5) begin #1 run_sw = 1; end
    end
    chk("prio_no_step", saw_step, 0);
    chk("prio_run", so0, S_RUN);
    #1 step_btn = 0;

    // Randomized run/step/breakpoint traffic with occasional async reset.
    do_reset();
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (hold == 0) begin
        step_btn = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 63) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 199) == 0) begin
        bp_en   = 1'($urandom_range(0, 1));
        bp_addr = 16'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1;
        #1;
        chk("async_rst_pe_1", pe0, 0);
        chk("async_rst_pe_3", pe1, 0);
        @(negedge clk); #1 rst = 0;
      end
    end

    // Free run long enough to saturate the cycle counter.
    do_reset();
    bp_en = 0; run_sw = 1;
    repeat (65545) @(negedge clk);
    chk("sat_cycle_cnt_1", cc0, 16'hFFFF);
    chk("sat_cycle_cnt_3", cc1, 16'hFFFF);
    repeat (4) @(negedge clk);
    chk("sat_hold", cc0, 16'hFFFF);
    chk("sat_still_run", pe0, 1);

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
